// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one SRAM read/write port between instruction fetch and load/store.
// Byte-masked stores are done as read-modify-write. Read data returns two cycles after the grant.
module sram_port_arbiter #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk0,
   input  logic                    rst0,
   input  logic                    i_req,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   output logic                    i_gnt,
   output logic                    i_rvalid,
   output logic [DATA_WIDTH-1:0]   i_rdata,
   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [DATA_WIDTH/8-1:0] d_wmask,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic [DATA_WIDTH-1:0]   d_wdata,
   output logic                    d_gnt,
   output logic                    d_rvalid,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   output logic                    sram_csb0,
   output logic                    sram_web0,
   output logic [ADDR_WIDTH-1:0]   sram_addr0,
   output logic [DATA_WIDTH-1:0]   sram_din0,
   input  logic [DATA_WIDTH-1:0]   sram_dout0
);

   localparam int MASK_WIDTH = DATA_WIDTH / 8;

   // The RMW read is issued from IDLE in the cycle the partial store wins,
   // so the merged write lands two cycles after the request.
   typedef enum logic [1:0] {IDLE, RMW_WAIT, RMW_WR} state_t;
   typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_t;

   state_t                  state_q, state_d;
   port_t                   last_q, last_d;
   logic [ADDR_WIDTH-1:0]   rmw_addr_q, rmw_addr_d;
   logic [MASK_WIDTH-1:0]   rmw_mask_q, rmw_mask_d;
   logic [DATA_WIDTH-1:0]   rmw_wdata_q, rmw_wdata_d;
   logic [DATA_WIDTH-1:0]   rmw_word_q, rmw_word_d;
   logic                    rd_vld_q, rd_vld_d;
   port_t                   rd_port_q, rd_port_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   din_q, din_d;
   logic                    i_rvalid_q, d_rvalid_q;
   logic [DATA_WIDTH-1:0]   i_rdata_q, d_rdata_q;
   logic                    cs, we, i_gnt_c, d_gnt_c, d_wins;
   logic [DATA_WIDTH-1:0]   merged;

   assign d_wins = d_req && (!i_req || last_q == PORT_I);

   always_comb begin
      merged = rmw_word_q;
      for (int k = 0; k < MASK_WIDTH; k++) begin
         if (rmw_mask_q[k]) merged[8*k +: 8] = rmw_wdata_q[8*k +: 8];
      end
   end

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      rmw_addr_d  = rmw_addr_q;
      rmw_mask_d  = rmw_mask_q;
      rmw_wdata_d = rmw_wdata_q;
      rmw_word_d  = rmw_word_q;
      rd_vld_d    = 1'b0;
      rd_port_d   = PORT_I;
      addr_d      = addr_q;
      din_d       = din_q;
      cs          = 1'b0;
      we          = 1'b0;
      i_gnt_c     = 1'b0;
      d_gnt_c     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (d_wins) begin
               if (!d_we) begin
                  cs        = 1'b1;
                  addr_d    = d_addr;
                  d_gnt_c   = 1'b1;
                  last_d    = PORT_D;
                  rd_vld_d  = 1'b1;
                  rd_port_d = PORT_D;
               end else if (&d_wmask) begin
                  cs      = 1'b1;
                  we      = 1'b1;
                  addr_d  = d_addr;
                  din_d   = d_wdata;
                  d_gnt_c = 1'b1;
                  last_d  = PORT_D;
               end else if (d_wmask == '0) begin
                  d_gnt_c = 1'b1;
                  last_d  = PORT_D;
               end else begin
                  cs          = 1'b1;
                  addr_d      = d_addr;
                  rmw_addr_d  = d_addr;
                  rmw_mask_d  = d_wmask;
                  rmw_wdata_d = d_wdata;
                  state_d     = RMW_WAIT;
               end
            end else if (i_req) begin
               cs        = 1'b1;
               addr_d    = i_addr;
               i_gnt_c   = 1'b1;
               last_d    = PORT_I;
               rd_vld_d  = 1'b1;
               rd_port_d = PORT_I;
            end
         end
         RMW_WAIT: begin
            rmw_word_d = sram_dout0;
            state_d    = RMW_WR;
         end
         RMW_WR: begin
            cs      = 1'b1;
            we      = 1'b1;
            addr_d  = rmw_addr_q;
            din_d   = merged;
            d_gnt_c = 1'b1;
            last_d  = PORT_D;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign sram_csb0  = rst0 | ~cs;
   assign sram_web0  = rst0 | ~we;
   assign sram_addr0 = addr_d;
   assign sram_din0  = din_d;
   assign i_gnt      = i_gnt_c & ~rst0;
   assign d_gnt      = d_gnt_c & ~rst0;
   assign i_rvalid   = i_rvalid_q & ~rst0;
   assign d_rvalid   = d_rvalid_q & ~rst0;
   assign i_rdata    = rst0 ? '0 : i_rdata_q;
   assign d_rdata    = rst0 ? '0 : d_rdata_q;

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk0) begin
      if (rst0) begin
         state_q    <= IDLE;
         last_q     <= PORT_I;
         rd_vld_q   <= 1'b0;
         rd_port_q  <= PORT_I;
         i_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
         i_rdata_q  <= '0;
         d_rdata_q  <= '0;
         addr_q     <= '0;
         din_q      <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         rd_vld_q   <= rd_vld_d;
         rd_port_q  <= rd_port_d;
         addr_q     <= addr_d;
         din_q      <= din_d;
         i_rvalid_q <= rd_vld_q && rd_port_q == PORT_I;
         d_rvalid_q <= rd_vld_q && rd_port_q == PORT_D;
         if (rd_vld_q && rd_port_q == PORT_I) i_rdata_q <= sram_dout0;
         if (rd_vld_q && rd_port_q == PORT_D) d_rdata_q <= sram_dout0;
      end
   end

   // NOTE: RMW datapath registers carry no reset; they are always written before being read.
   always_ff @(posedge clk0) begin
      rmw_addr_q  <= rmw_addr_d;
      rmw_mask_q  <= rmw_mask_d;
      rmw_wdata_q <= rmw_wdata_d;
      rmw_word_q  <= rmw_word_d;
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural model of the 32x1024 SRAM macro.
module tb_sram_port_arbiter;

   logic        clk0 = 1'b0;
   logic        rst0 = 1'b1;
   logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [9:0]  i_addr = '0, d_addr = '0;
   logic [3:0]  d_wmask = '0;
   logic [31:0] d_wdata = '0;
   logic        i_gnt, i_rvalid, d_gnt, d_rvalid, sram_csb0, sram_web0;
   logic [31:0] i_rdata, d_rdata, sram_din0, sram_dout0;
   logic [9:0]  sram_addr0;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk0 = ~clk0;

   sram_port_arbiter dut (
      .clk0(clk0), .rst0(rst0),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_wmask(d_wmask), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
      .sram_din0(sram_din0), .sram_dout0(sram_dout0)
   );

   // SRAM model: command sampled at posedge, write or read performed at the following negedge.
   logic [31:0] mem [1024];
   logic        csb_r = 1'b1, web_r = 1'b1;
   logic [9:0]  addr_r = '0;
   logic [31:0] din_r = '0;

   always @(posedge clk0) begin
      csb_r  <= sram_csb0;
      web_r  <= sram_web0;
      addr_r <= sram_addr0;
      din_r  <= sram_din0;
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'(i * 4);
      mem[10'h50] = 32'h1122_3344;
      sram_dout0 = '0;
      forever begin
         @(negedge clk0);
         if (!csb_r) begin
            if (!web_r) mem[addr_r] = din_r;
            else        sram_dout0 <= #2 mem[addr_r];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk0);
      #1;
   endtask

   task automatic idle_inputs();
      i_req   = 1'b0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_wmask = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected finish before 200000");
      $fatal(1);
   end

   initial begin
      // Reset with both ports requesting.
      step();
      i_req = 1'b1;
      d_req = 1'b1;
      step();
      #1;
      check("rst_i_gnt", 32'(i_gnt), 0);
      check("rst_d_gnt", 32'(d_gnt), 0);
      check("rst_csb", 32'(sram_csb0), 1);
      check("rst_web", 32'(sram_web0), 1);
      check("rst_i_rvalid", 32'(i_rvalid), 0);
      check("rst_d_rvalid", 32'(d_rvalid), 0);
      check("rst_i_rdata", i_rdata, 0);
      check("rst_d_rdata", d_rdata, 0);
      idle_inputs();
      rst0 = 1'b0;
      step();

      // Fetch-only stream of addresses 0..7.
      for (int c = 0; c < 10; c++) begin
         if (c < 8) begin
            i_req  = 1'b1;
            i_addr = 10'(c);
         end else begin
            i_req = 1'b0;
         end
         #1;
         check("fetch_gnt", 32'(i_gnt), 32'(c < 8));
         check("fetch_rvalid", 32'(i_rvalid), 32'(c >= 2));
         if (c >= 2) check("fetch_rdata", i_rdata, 32'((c - 2) * 4));
         check("fetch_no_d_rvalid", 32'(d_rvalid), 0);
         step();
      end

      // Both ports requesting: D,I,D,I,... with per-port return data.
      for (int k = 0; k < 8; k++) begin
         if (k < 6) begin
            i_req  = 1'b1;
            i_addr = 10'(100 + k / 2);
            d_req  = 1'b1;
            d_we   = 1'b0;
            d_addr = 10'(200 + (k + 1) / 2);
         end else begin
            idle_inputs();
         end
         #1;
         check("rr_d_gnt", 32'(d_gnt), 32'(k < 6 && k % 2 == 0));
         check("rr_i_gnt", 32'(i_gnt), 32'(k < 6 && k % 2 == 1));
         if (k >= 2 && (k - 2) % 2 == 0) begin
            check("rr_d_rvalid", 32'(d_rvalid), 1);
            check("rr_i_quiet", 32'(i_rvalid), 0);
            check("rr_d_rdata", d_rdata, 32'((200 + (k - 2) / 2) * 4));
         end else if (k >= 2) begin
            check("rr_i_rvalid", 32'(i_rvalid), 1);
            check("rr_d_quiet", 32'(d_rvalid), 0);
            check("rr_i_rdata", i_rdata, 32'((100 + (k - 3) / 2) * 4));
         end else begin
            check("rr_no_rvalid", 32'({i_rvalid, d_rvalid}), 0);
         end
         step();
      end

      // Full store at the top address, then load it back.
      d_req = 1'b1; d_we = 1'b1; d_wmask = 4'hF; d_addr = 10'h3FF; d_wdata = 32'hDEAD_BEEF;
      #1;
      check("fs_gnt", 32'(d_gnt), 1);
      check("fs_csb", 32'(sram_csb0), 0);
      check("fs_web", 32'(sram_web0), 0);
      check("fs_addr", 32'(sram_addr0), 32'h3FF);
      check("fs_din", sram_din0, 32'hDEAD_BEEF);
      step();
      d_we = 1'b0;
      #1;
      check("fs_load_gnt", 32'(d_gnt), 1);
      check("fs_load_web", 32'(sram_web0), 1);
      step();
      idle_inputs();
      #1;
      check("fs_no_rvalid", 32'(d_rvalid), 0);
      check("fs_idle_csb", 32'(sram_csb0), 1);
      check("fs_addr_hold", 32'(sram_addr0), 32'h3FF);
      step();
      #1;
      check("fs_rvalid", 32'(d_rvalid), 1);
      check("fs_rdata", d_rdata, 32'hDEAD_BEEF);
      step();
      #1;
      check("fs_rvalid_pulse", 32'(d_rvalid), 0);
      check("fs_rdata_hold", d_rdata, 32'hDEAD_BEEF);
      step();

      // Partial store 0101 of AABBCCDD over 11223344.
      d_req = 1'b1; d_we = 1'b1; d_wmask = 4'b0101; d_addr = 10'h50; d_wdata = 32'hAABB_CCDD;
      #1;
      check("rmw_rd_gnt", 32'(d_gnt), 0);
      check("rmw_rd_csb", 32'(sram_csb0), 0);
      check("rmw_rd_web", 32'(sram_web0), 1);
      check("rmw_rd_addr", 32'(sram_addr0), 32'h50);
      step();
      i_req = 1'b1; i_addr = 10'd7;
      #1;
      check("rmw_wait_d_gnt", 32'(d_gnt), 0);
      check("rmw_wait_i_gnt", 32'(i_gnt), 0);
      check("rmw_wait_csb", 32'(sram_csb0), 1);
      step();
      #1;
      check("rmw_wr_d_gnt", 32'(d_gnt), 1);
      check("rmw_wr_i_gnt", 32'(i_gnt), 0);
      check("rmw_wr_web", 32'(sram_web0), 0);
      check("rmw_wr_csb", 32'(sram_csb0), 0);
      check("rmw_wr_din", sram_din0, 32'h11BB_33DD);
      check("rmw_no_rvalid", 32'(d_rvalid), 0);
      step();
      d_req = 1'b0;
      #1;
      check("rmw_after_i_gnt", 32'(i_gnt), 1);
      check("rmw_after_no_rvalid", 32'(d_rvalid), 0);
      step();
      i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 10'h50;
      #1;
      check("rmw_load_gnt", 32'(d_gnt), 1);
      step();
      idle_inputs();
      #1;
      check("rmw_fetch_rvalid", 32'(i_rvalid), 1);
      check("rmw_fetch_rdata", i_rdata, 32'h1C);
      step();
      #1;
      check("rmw_load_rvalid", 32'(d_rvalid), 1);
      check("rmw_load_rdata", d_rdata, 32'h11BB_33DD);
      step();

      // Empty store: granted at once, SRAM untouched.
      d_req = 1'b1; d_we = 1'b1; d_wmask = 4'b0000; d_addr = 10'd6; d_wdata = 32'hFFFF_FFFF;
      #1;
      check("es_gnt", 32'(d_gnt), 1);
      check("es_csb", 32'(sram_csb0), 1);
      step();
      d_we = 1'b0;
      #1;
      check("es_load_gnt", 32'(d_gnt), 1);
      step();
      idle_inputs();
      step();
      #1;
      check("es_rvalid", 32'(d_rvalid), 1);
      check("es_rdata", d_rdata, 32'h18);
      step();

      // Reset during RMW_WAIT, with a fetch still in flight.
      i_req = 1'b1; i_addr = 10'd3;
      #1;
      check("rr6_fetch_gnt", 32'(i_gnt), 1);
      step();
      i_req = 1'b0;
      d_req = 1'b1; d_we = 1'b1; d_wmask = 4'b0011; d_addr = 10'd9; d_wdata = 32'hFFFF_FFFF;
      #1;
      check("rr6_rmw_gnt", 32'(d_gnt), 0);
      step();
      idle_inputs();
      rst0 = 1'b1;
      #1;
      check("rr6_rst_d_gnt", 32'(d_gnt), 0);
      check("rr6_rst_csb", 32'(sram_csb0), 1);
      check("rr6_rst_web", 32'(sram_web0), 1);
      check("rr6_rst_i_rvalid", 32'(i_rvalid), 0);
      step();
      rst0 = 1'b0;
      #1;
      check("rr6_post_i_rvalid", 32'(i_rvalid), 0);
      check("rr6_post_d_rvalid", 32'(d_rvalid), 0);
      check("rr6_post_d_rdata", d_rdata, 0);
      check("rr6_post_csb", 32'(sram_csb0), 1);
      step();
      d_req = 1'b1; d_we = 1'b0; d_addr = 10'd9;
      #1;
      check("rr6_load_gnt", 32'(d_gnt), 1);
      step();
      idle_inputs();
      #1;
      check("rr6_mem_unchanged", mem[9], 32'h24);
      step();
      #1;
      check("rr6_load_rvalid", 32'(d_rvalid), 1);
      check("rr6_load_rdata", d_rdata, 32'h24);
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
